// File: rtl/f_meter_module.sv
// Reciprocal frequency / duty meter: gates on rising edges of a synchronised strobe
// and reports edge, reference-clock and high-time counts over the closed gate.
module f_meter_module #(
   parameter int GATE_CYCLES    = 50_000_000,
   parameter int TIMEOUT_CYCLES = 100_000_000,
   parameter int CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             continuous,
   input  logic             sig_in,
   output logic             busy,
   output logic             valid,
   output logic             timeout,
   output logic [CNT_W-1:0] edge_cnt,
   output logic [CNT_W-1:0] ref_cnt,
   output logic [CNT_W-1:0] high_cnt
);

   localparam int               TW         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] GATE_LAST  = CNT_W'(GATE_CYCLES - 1);
   localparam logic [TW-1:0]    TOUT_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_s1, r_s2, r_s3;
   logic             w_rise, w_level;
   logic [TW-1:0]    r_tout;
   logic [CNT_W-1:0] r_gate_tmr;
   logic [CNT_W-1:0] r_edge_acc, r_ref_acc, r_high_acc;
   logic [CNT_W-1:0] w_edge_nxt, w_ref_nxt, w_high_nxt;
   logic             w_close, w_tout_hit, w_enter_arm;
   logic             r_timeout;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      if (en && (v != {CNT_W{1'b1}}))
         return v + 1'b1;
      return v;
   endfunction

   assign w_rise  = r_s2 & ~r_s3;
   assign w_level = r_s3;

   // Close wins over a coincident timeout.
   assign w_close    = (r_state == GATE) && w_rise && (r_gate_tmr >= GATE_LAST);
   assign w_tout_hit = ((r_state == ARM) || (r_state == GATE)) && (r_tout == TOUT_LAST) && !w_close;

   assign w_edge_nxt = sat_inc(r_edge_acc, w_rise);
   assign w_ref_nxt  = sat_inc(r_ref_acc, 1'b1);
   assign w_high_nxt = sat_inc(r_high_acc, w_level);

   assign busy    = (r_state != IDLE);
   assign valid   = (r_state == DONE);
   assign timeout = r_timeout;

   always_comb begin
      w_state_nxt = r_state;
      w_enter_arm = 1'b0;
      case (r_state)
         IDLE: begin
            if (start || continuous) begin
               w_state_nxt = ARM;
               w_enter_arm = 1'b1;
            end
         end
         ARM: begin
            if (w_rise)
               w_state_nxt = GATE;
         end
         GATE: begin
            if (w_close)
               w_state_nxt = DONE;
         end
         DONE: begin
            w_state_nxt = continuous ? ARM : IDLE;
            w_enter_arm = continuous;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_tout_hit) begin
         w_state_nxt = continuous ? ARM : IDLE;
         w_enter_arm = continuous;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_s3      <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_s1      <= sig_in;
         r_s2      <= r_s1;
         r_s3      <= r_s2;
         r_timeout <= w_tout_hit;
      end
   end

   // Accumulators are cleared on every entry to ARM, including a re-arm after timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tout     <= '0;
         r_gate_tmr <= '0;
         r_edge_acc <= '0;
         r_ref_acc  <= '0;
         r_high_acc <= '0;
      end else if (w_enter_arm) begin
         r_tout     <= '0;
         r_gate_tmr <= '0;
         r_edge_acc <= '0;
         r_ref_acc  <= '0;
         r_high_acc <= '0;
      end else if (r_state == ARM) begin
         r_tout <= r_tout + 1'b1;
         if (w_rise)
            r_gate_tmr <= '0;
      end else if (r_state == GATE) begin
         r_tout     <= r_tout + 1'b1;
         r_gate_tmr <= sat_inc(r_gate_tmr, 1'b1);
         r_edge_acc <= w_edge_nxt;
         r_ref_acc  <= w_ref_nxt;
         r_high_acc <= w_high_nxt;
      end
   end

   // Results are captured with the closing cycle included, so they are stable while valid=1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_cnt <= '0;
         ref_cnt  <= '0;
         high_cnt <= '0;
      end else if (w_close) begin
         edge_cnt <= w_edge_nxt;
         ref_cnt  <= w_ref_nxt;
         high_cnt <= w_high_nxt;
      end
   end

endmodule

// File: tb/tb_f_meter_module.sv
// Scoreboard bench for f_meter_module: expected results are queued by the stimulus
// thread and popped by a monitor whenever valid or timeout pulses.
module tb_f_meter_module;

   logic        clk;
   logic        rst;
   logic        start;
   logic        continuous;
   logic        sig_in;
   logic        busy;
   logic        valid;
   logic        timeout;
   logic [31:0] edge_cnt;
   logic [31:0] ref_cnt;
   logic [31:0] high_cnt;

   typedef struct {
      bit          is_tout;
      int unsigned e;
      int unsigned r;
      int unsigned h;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   int   sig_period = 10;
   int   sig_high   = 5;
   bit   sig_en     = 0;

   f_meter_module #(
      .GATE_CYCLES(100),
      .TIMEOUT_CYCLES(1000),
      .CNT_W(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .continuous(continuous),
      .sig_in(sig_in),
      .busy(busy),
      .valid(valid),
      .timeout(timeout),
      .edge_cnt(edge_cnt),
      .ref_cnt(ref_cnt),
      .high_cnt(high_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Signal generator: phase 0 is always a rising edge, so enabling gives whole periods.
   initial begin
      int ph;
      ph = 0;
      sig_in = 1'b0;
      forever begin
         @(negedge clk);
         if (!sig_en) begin
            sig_in = 1'b0;
            ph = 0;
         end else begin
            sig_in = (ph < sig_high);
            ph = (ph + 1 >= sig_period) ? 0 : ph + 1;
         end
      end
   end

   // Monitor / scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (valid || timeout) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: valid=%0b timeout=%0b with empty queue", valid, timeout);
            end else begin
               e = q.pop_front();
               check("sb_valid",   {31'd0, valid},   {31'd0, !e.is_tout});
               check("sb_timeout", {31'd0, timeout}, {31'd0, e.is_tout});
               check("sb_edge_cnt", edge_cnt, e.e);
               check("sb_ref_cnt",  ref_cnt,  e.r);
               check("sb_high_cnt", high_cnt, e.h);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   task automatic push(input bit t, input int unsigned e, input int unsigned r, input int unsigned h);
      exp_t x;
      x.is_tout = t;
      x.e = e;
      x.r = r;
      x.h = h;
      q.push_back(x);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int budget);
      int cnt;
      cnt = 0;
      @(negedge clk);
      while (!valid && cnt < budget) begin
         @(negedge clk);
         cnt++;
      end
      check(name, {31'd0, valid}, 32'd1);
   endtask

   task automatic set_sig(input int per, input int hi);
      sig_en = 0;
      repeat (3) @(negedge clk);
      sig_period = per;
      sig_high   = hi;
      sig_en     = 1;
   endtask

   initial begin
      int bc;
      int extra;
      rst = 1'b1;
      start = 1'b0;
      continuous = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy",     {31'd0, busy},    32'd0);
      check("rst_valid",    {31'd0, valid},   32'd0);
      check("rst_timeout",  {31'd0, timeout}, 32'd0);
      check("rst_edge_cnt", edge_cnt, 32'd0);
      check("rst_ref_cnt",  ref_cnt,  32'd0);
      check("rst_high_cnt", high_cnt, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single measurement, period 10 (5/5).
      set_sig(10, 5);
      push(0, 10, 100, 50);
      pulse_start();
      check("t1_busy_after_start", {31'd0, busy}, 32'd1);
      wait_valid("t1_valid_seen", 400);
      @(negedge clk);
      check("t1_busy_after_valid", {31'd0, busy}, 32'd0);

      // Timeout with sig_in held low; previous results must persist.
      sig_en = 0;
      repeat (5) @(negedge clk);
      push(1, 10, 100, 50);
      pulse_start();
      bc = busy ? 1 : 0;
      for (int i = 0; i < 3000 && !timeout; i++) begin
         @(negedge clk);
         if (busy) bc++;
      end
      check("t3_timeout_seen",  {31'd0, timeout}, 32'd1);
      check("t3_busy_cycles",   bc, 32'd1000);
      @(negedge clk);
      check("t3_busy_after",    {31'd0, busy}, 32'd0);

      // Period 7 (3/4): gate closes on the 15th edge.
      set_sig(7, 3);
      push(0, 15, 105, 45);
      pulse_start();
      wait_valid("t2_valid_seen", 400);
      @(negedge clk);
      check("t2_busy_after_valid", {31'd0, busy}, 32'd0);

      // Continuous mode, then drop continuous mid-gate.
      set_sig(10, 5);
      push(0, 10, 100, 50);
      push(0, 10, 100, 50);
      continuous = 1'b1;
      wait_valid("t4_valid1_seen", 400);
      wait_valid("t4_valid2_seen", 400);
      push(0, 10, 100, 50);
      repeat (50) @(negedge clk);
      check("t4_busy_mid_gate", {31'd0, busy}, 32'd1);
      continuous = 1'b0;
      wait_valid("t4_valid3_seen", 400);
      @(negedge clk);
      check("t4_busy_after_last", {31'd0, busy}, 32'd0);
      extra = 0;
      repeat (300) begin
         @(negedge clk);
         if (valid || busy) extra++;
      end
      check("t4_stays_idle", extra, 32'd0);

      // Reset mid-gate, then a clean measurement.
      pulse_start();
      repeat (50) @(negedge clk);
      check("t5_busy_before_rst", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("t5_rst_busy",     {31'd0, busy}, 32'd0);
      check("t5_rst_edge_cnt", edge_cnt, 32'd0);
      check("t5_rst_ref_cnt",  ref_cnt,  32'd0);
      check("t5_rst_high_cnt", high_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      push(0, 10, 100, 50);
      pulse_start();
      wait_valid("t5_valid_seen", 400);

      // Extra start pulses during ARM and GATE are ignored.
      repeat (5) @(negedge clk);
      push(0, 10, 100, 50);
      pulse_start();
      repeat (2) @(negedge clk);
      pulse_start();
      repeat (40) @(negedge clk);
      pulse_start();
      wait_valid("t6_valid_seen", 400);
      extra = 0;
      repeat (300) begin
         @(negedge clk);
         if (valid || busy) extra++;
      end
      check("t6_no_second_measure", extra, 32'd0);

      check("scoreboard_empty", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
